// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    localparam int unsigned IN_W_DEF   = 32;
    localparam int unsigned DIGITS_DEF = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int unsigned cnt_w(input int unsigned in_w);
        return (in_w > 1) ? $clog2(in_w) : 1;
    endfunction

    localparam int unsigned CNT_W = cnt_w(IN_W_DEF);

    // Largest value representable in the given number of decimal digits.
    function automatic logic [63:0] bcd_max(input int unsigned digits);
        logic [63:0] m;
        m = 64'd1;
        for (int unsigned i = 0; i < digits; i++) begin
            m = m * 64'd10;
        end
        return m - 64'd1;
    endfunction

    // Saturation pattern: every nibble set to 9.
    function automatic logic [127:0] nines(input int unsigned digits);
        logic [127:0] r;
        r = '0;
        for (int unsigned i = 0; i < digits && i < 32; i++) begin
            r[4*i +: 4] = 4'h9;
        end
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble that is 5 or more.
module bcd_add3 (
    input  logic [3:0] nibble,
    output logic [3:0] adjusted_c
);

    always_comb begin
        adjusted_c = (nibble >= 4'd5) ? 4'(nibble + 4'd3) : nibble;
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter, one bit per clock, saturating.
// Optional BIN2BCD_BLANK_EN adds a per-digit leading-zero blank output.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned IN_W   = IN_W_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin_in,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  overflow
`ifdef BIN2BCD_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CW    = cnt_w(IN_W);
    localparam logic [63:0] BCD_MAX = bcd_max(DIGITS);
    localparam logic [BCD_W-1:0] NINES = BCD_W'(nines(DIGITS));

    state_t             state;
    logic [IN_W-1:0]    shreg;
    logic [BCD_W-1:0]   acc;
    logic [CW-1:0]      cnt;
    logic               ovf_pending;

    logic [BCD_W-1:0]   acc_adj_c;
    logic [BCD_W-1:0]   acc_next_c;
    logic [IN_W-1:0]    sh_next_c;
    logic [BCD_W-1:0]   result_c;
    logic               over_range_c;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .nibble     (acc[4*g +: 4]),
            .adjusted_c (acc_adj_c[4*g +: 4])
        );
    end

    // Corrected accumulator and shift register move left as one word; top carry drops.
    assign {acc_next_c, sh_next_c} = {acc_adj_c, shreg} << 1;
    assign result_c     = ovf_pending ? NINES : acc_next_c;
    assign over_range_c = 64'(bin_in) > BCD_MAX;

`ifdef BIN2BCD_BLANK_EN
    logic [DIGITS-1:0] blank_c;

    // A digit blanks when it and every digit above it are zero; digit 0 always shows.
    always_comb begin
        logic seen;
        seen    = 1'b0;
        blank_c = '0;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            seen       = seen | (|result_c[4*i +: 4]);
            blank_c[i] = ~seen;
        end
    end
`endif

    always_ff @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            shreg       <= '0;
            acc         <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            bcd_out     <= '0;
            overflow    <= 1'b0;
`ifdef BIN2BCD_BLANK_EN
            blank       <= {{(DIGITS-1){1'b1}}, 1'b0};
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        shreg       <= bin_in;
                        acc         <= '0;
                        cnt         <= '0;
                        ovf_pending <= over_range_c;
                        busy        <= 1'b1;
                        state       <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    acc   <= acc_next_c;
                    shreg <= sh_next_c;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(IN_W - 1)) begin
                        bcd_out  <= result_c;
                        overflow <= ovf_pending;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= ST_IDLE;
`ifdef BIN2BCD_BLANK_EN
                        blank    <= blank_c;
`endif
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: decimal-arithmetic reference model plus directed and random stimulus.
module tb_bin2bcd_seq;

    localparam int unsigned IN_W   = 32;
    localparam int unsigned DIGITS = 8;
    localparam longint unsigned MAXV = 64'd99999999;

    logic        CLOCK_50 = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic [31:0] bin_in   = '0;
    logic        busy;
    logic        done;
    logic [31:0] bcd_out;
    logic        overflow;
`ifdef BIN2BCD_BLANK_EN
    logic [7:0]  blank;
`endif

    int errors = 0;
    int checks = 0;
    bit run_chk = 1'b0;

    bin2bcd_seq #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .start    (start),
        .bin_in   (bin_in),
        .busy     (busy),
        .done     (done),
        .bcd_out  (bcd_out),
        .overflow (overflow)
`ifdef BIN2BCD_BLANK_EN
        ,
        .blank    (blank)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Decimal digits by repeated division, saturating above the 8-digit range.
    function automatic logic [31:0] ref_bcd(input logic [31:0] v);
        longint unsigned x;
        logic [31:0] r;
        x = 64'(v);
        if (x > MAXV) return 32'h99999999;
        r = '0;
        for (int d = 0; d < 8; d++) begin
            r[4*d +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] ref_blank(input logic [31:0] b);
        logic [7:0] r;
        r = '0;
        for (int i = 1; i < 8; i++) r[i] = ((b >> (4*i)) == 32'd0);
        return r;
    endfunction

    // Transaction-level model: a conversion finishes IN_W edges after acceptance.
    int          remaining = 0;
    logic        exp_busy = 0, exp_done = 0, exp_ovf = 0, pend_ovf = 0;
    logic [31:0] exp_bcd = '0, pend_bcd = '0;
    logic [7:0]  exp_blank = 8'hFE;

    always @(posedge CLOCK_50 or negedge reset) begin
        if (!reset) begin
            remaining = 0;
            exp_busy  = 0;
            exp_done  = 0;
            exp_bcd   = '0;
            exp_ovf   = 0;
            exp_blank = 8'hFE;
        end else begin
            exp_done = 0;
            if (remaining > 0) begin
                remaining--;
                if (remaining == 0) begin
                    exp_done  = 1;
                    exp_busy  = 0;
                    exp_bcd   = pend_bcd;
                    exp_ovf   = pend_ovf;
                    exp_blank = ref_blank(pend_bcd);
                end
            end else if (start) begin
                pend_bcd  = ref_bcd(bin_in);
                pend_ovf  = (64'(bin_in) > MAXV);
                remaining = IN_W;
                exp_busy  = 1;
            end
        end
    end

    always @(negedge CLOCK_50) begin
        if (run_chk) begin
            check("busy", busy, exp_busy);
            check("done", done, exp_done);
            check("bcd_out", bcd_out, exp_bcd);
            check("overflow", overflow, exp_ovf);
`ifdef BIN2BCD_BLANK_EN
            check("blank", blank, exp_blank);
`endif
        end
    end

    // Start a conversion and wait (bounded) for done; optional ignored start pulse mid-way.
    task automatic convert(input logic [31:0] v, input logic [31:0] exp_b, input logic exp_o,
                           input int pulse_at, input bit now);
        int lat;
        int busy_cnt;
        lat = -1;
        busy_cnt = 0;
        if (!now) @(negedge CLOCK_50);
        start  = 1'b1;
        bin_in = v;
        @(negedge CLOCK_50);
        start  = 1'b0;
        bin_in = $urandom;
        for (int i = 0; i <= 40; i++) begin
            if (i > 0) @(negedge CLOCK_50);
            if (i == pulse_at) begin
                start  = 1'b1;
                bin_in = 32'd55;
            end else if (i == pulse_at + 1) begin
                start  = 1'b0;
            end
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (busy === 1'b1) busy_cnt++;
        end
        check("latency", 64'(lat), 64'd32);
        check("busy_cycles", 64'(busy_cnt), 64'd32);
        check("result", bcd_out, exp_b);
        check("result_ovf", overflow, exp_o);
    endtask

    initial begin
        int done_seen;
        run_chk = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge CLOCK_50);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_bcd", bcd_out, 32'h0);
        check("rst_ovf", overflow, 1'b0);
        check("model_pin_a", ref_bcd(32'd12345678), 32'h12345678);
        check("model_pin_b", ref_bcd(32'd100000000), 32'h99999999);
        check("model_pin_c", ref_blank(32'h00000405), 8'b11111000);
        reset = 1'b1;

        convert(32'd0,          32'h00000000, 1'b0, -1, 1'b0);
        convert(32'h00BC614E,   32'h12345678, 1'b0, -1, 1'b0);
        convert(32'd99999999,   32'h99999999, 1'b0, -1, 1'b0);
        convert(32'd100000000,  32'h99999999, 1'b1, -1, 1'b0);
        convert(32'hFFFFFFFF,   32'h99999999, 1'b1, -1, 1'b0);
        convert(32'd1000,       32'h00001000, 1'b0, 10, 1'b0);
        convert(32'd55,         32'h00000055, 1'b0, -1, 1'b1);
`ifdef BIN2BCD_BLANK_EN
        convert(32'd405,        32'h00000405, 1'b0, -1, 1'b0);
        check("blank_405", blank, 8'b11111000);
        convert(32'd0,          32'h00000000, 1'b0, -1, 1'b0);
        check("blank_0", blank, 8'b11111110);
`endif

        // Reset in the middle of a conversion abandons it without a done pulse.
        @(negedge CLOCK_50);
        start  = 1'b1;
        bin_in = 32'd87654321;
        @(negedge CLOCK_50);
        start  = 1'b0;
        repeat (15) @(negedge CLOCK_50);
        #1 reset = 1'b0;
        #1;
        check("async_busy", busy, 1'b0);
        check("async_done", done, 1'b0);
        check("async_bcd", bcd_out, 32'h0);
        check("async_ovf", overflow, 1'b0);
        @(negedge CLOCK_50);
        reset = 1'b1;
        done_seen = 0;
        repeat (40) begin
            @(negedge CLOCK_50);
            if (done === 1'b1) done_seen++;
        end
        check("no_done_after_rst", 64'(done_seen), 64'd0);
        convert(32'd87654321, 32'h87654321, 1'b0, -1, 1'b0);

        // Random traffic, including starts while busy and occasional async resets.
        for (int n = 0; n < 2000; n++) begin
            @(negedge CLOCK_50);
            start = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0: bin_in = $urandom;
                1: bin_in = $urandom_range(0, 99999999);
                2: bin_in = $urandom_range(0, 999);
                default: begin
                    case ($urandom_range(0, 4))
                        0: bin_in = 32'd99999999;
                        1: bin_in = 32'd100000000;
                        2: bin_in = 32'd0;
                        3: bin_in = 32'd9;
                        default: bin_in = 32'hFFFFFFFF;
                    endcase
                end
            endcase
            if ($urandom_range(0, 499) == 0) begin
                #2 reset = 1'b0;
                @(negedge CLOCK_50);
                reset = 1'b1;
            end
        end
        start = 1'b0;
        repeat (40) @(negedge CLOCK_50);
        run_chk = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
